key_debounce: RTL and testbench

- Upstream front end for every push-button input. It takes a raw, asynchronous, bouncing key pin and delivers clean, clock-aligned events to the key-driven FSMs (LED mode cycler and similar).
- Provides a one-cycle press pulse (key_flag), a debounced level, a one-cycle release pulse and a one-cycle long-press pulse.
- Consumers advance state only on key_flag.

---
 rtl/key_debounce_pkg.sv | 20 ++
 rtl/key_sync.sv | 24 ++
 rtl/key_debounce.sv | 107 ++++++++++
 tb/tb_key_debounce.sv | 130 +++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer: one-hot FSM states,
// default timing constants and the counter-width helper.
package key_debounce_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    PRESS_FLT = 4'b0010,
    DOWN      = 4'b0100,
    REL_FLT   = 4'b1000
  } state_t;

  localparam int DEF_DEB_CNT  = 1000000;   // 20 ms at 50 MHz
  localparam int DEF_LONG_CNT = 50000000;  // 1 s at 50 MHz

  // A counter must hold 0..n-1; never return a zero width.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous input; the reset level is a
// parameter so an idle pin does not look like an event after reset.
module key_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw key pin into press / release / long-press pulses and a
// clean pressed level, all registered and aligned to clk.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEB_CNT    = DEF_DEB_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_long,
  output logic key_state
);

  localparam int DEB_W  = cnt_width(DEB_CNT);
  localparam int HOLD_W = cnt_width(LONG_CNT);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CNT - 2);

  logic key_sync_q;
  logic act;

  // Flops reset to the released pin level so reset never fakes a press.
  key_sync #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_sync_q)
  );

  assign act = key_sync_q ^ ACTIVE_LOW;

  state_t            state;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            state   <= PRESS_FLT;
            deb_cnt <= '0;
          end
        end
        PRESS_FLT: begin
          if (!act) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_MAX) begin
            state     <= DOWN;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        DOWN: begin
          // Saturation guarantees key_long fires once per press.
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
            key_long <= (hold_cnt == HOLD_PRE);
          end
          if (!act) begin
            state   <= REL_FLT;
            deb_cnt <= '0;
          end
        end
        REL_FLT: begin
          if (act) begin
            state <= DOWN;
          end else if (deb_cnt == DEB_MAX) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_state   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          deb_cnt   <= '0;
          hold_cnt  <= '0;
          key_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing (DEB_CNT=4, LONG_CNT=16).
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_flag, key_release, key_long, key_state;

  int n_cmp  = 0;
  int n_fail = 0;

  key_debounce #(.DEB_CNT(4), .LONG_CNT(16), .ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_flag    (key_flag),
    .key_release (key_release),
    .key_long    (key_long),
    .key_state   (key_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int step, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %b expected %b", tag, step, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flag"},    0, key_flag,    1'b0);
    chk({tag, "_release"}, 0, key_release, 1'b0);
    chk({tag, "_long"},    0, key_long,    1'b0);
    chk({tag, "_state"},   0, key_state,   1'b0);
  endtask

  initial begin
    // Reset with the pin idle (high)
    rst_n  = 1'b0;
    key_in = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) tick();
    chk_all_zero("idle");

    // Clean press held 40 cycles: key_flag after edge 6, key_long after edge 21
    key_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("press_flag",  i, key_flag,    (i == 6));
      chk("press_state", i, key_state,   (i >= 6));
      chk("press_long",  i, key_long,    (i == 21));
      chk("press_rel",   i, key_release, 1'b0);
    end

    // Clean release: key_release after edge 6
    key_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rel_release", i, key_release, (i == 6));
      chk("rel_state",   i, key_state,   (i < 6));
      chk("rel_flag",    i, key_flag,    1'b0);
      chk("rel_long",    i, key_long,    1'b0);
    end

    // Press bounce 0,0,0,1,0,0,1 then high: never reaches DEB_CNT stable cycles
    for (int i = 0; i < 17; i++) begin
      key_in = (i < 7) ? ((i == 3 || i == 6) ? 1'b1 : 1'b0) : 1'b1;
      tick();
      chk("bounce_flag",  i, key_flag,  1'b0);
      chk("bounce_state", i, key_state, 1'b0);
    end

    // Press with a 2-cycle release glitch at edges 11,12: key_long slips from 21 to 23
    for (int i = 0; i < 36; i++) begin
      key_in = (i == 11 || i == 12) ? 1'b1 : 1'b0;
      tick();
      chk("glitch_flag",  i, key_flag,    (i == 6));
      chk("glitch_state", i, key_state,   (i >= 6));
      chk("glitch_rel",   i, key_release, 1'b0);
      chk("glitch_long",  i, key_long,    (i == 23));
    end

    // Asynchronous reset mid-cycle while pressed: outputs clear before the next edge
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    key_in = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_all_zero("post_rst");

    // Reset during PRESS_FLT with the key still held
    key_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_pre_flag", i, key_flag, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_hold_flag", i, key_flag, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("mid_flag",  i, key_flag,  (i == 6));
      chk("mid_state", i, key_state, (i >= 6));
    end

    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_release", i, key_release, (i == 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
